// File: rtl/sdram_burst_master.sv
// Burst request engine for the SDRAM controller user ports: watches FIFO fill levels,
// arbitrates write/read bursts and walks circular address pointers for each direction.
module sdram_burst_master #(
    parameter logic [23:0] WR_MIN_ADDR = 24'd0,
    parameter logic [23:0] WR_MAX_ADDR = 24'd786432,
    parameter logic [23:0] RD_MIN_ADDR = 24'd0,
    parameter logic [23:0] RD_MAX_ADDR = 24'd786432,
    parameter logic [9:0]  BURST_LEN   = 10'd512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_init_done,
    input  logic [9:0]  wrf_use,
    input  logic [9:0]  rdf_use,
    input  logic        rd_en,
    input  logic        wr_load,
    input  logic        rd_load,
    output logic        sdram_wr_req,
    input  logic        sdram_wr_ack,
    output logic [23:0] sdram_wr_addr,
    output logic [9:0]  sdram_wr_burst,
    output logic        sdram_rd_req,
    input  logic        sdram_rd_ack,
    output logic [23:0] sdram_rd_addr,
    output logic [9:0]  sdram_rd_burst,
    output logic        wrf_rden,
    output logic        rdf_wren,
    output logic        burst_err
);

    // state | meaning
    // IDLE  | no burst in flight, arbitrating
    // WRITE | write burst requested / in progress
    // READ  | read burst requested / in progress
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t      state_q, state_d;
    logic        wr_req_q, wr_req_d, rd_req_q, rd_req_d;
    logic [23:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [9:0]  ack_cnt_q, ack_cnt_d;
    logic        wr_ack_d_q, rd_ack_d_q;
    logic        last_wr_q, last_wr_d;
    logic        wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
    logic        burst_err_q, burst_err_d;

    logic        wc, rc, wr_done, rd_done;
    logic [24:0] wr_sum, rd_sum;
    logic [23:0] wr_next, rd_next;

    always_comb begin
        wc      = sdram_init_done && (wrf_use >= BURST_LEN);
        rc      = sdram_init_done && rd_en && (rdf_use < BURST_LEN);
        // Done needs req already up so a stray ack seen in IDLE cannot end a burst early.
        wr_done = (state_q == WRITE) && wr_req_q && wr_ack_d_q && !sdram_wr_ack;
        rd_done = (state_q == READ) && rd_req_q && rd_ack_d_q && !sdram_rd_ack;
        wr_sum  = {1'b0, wr_addr_q} + {15'd0, BURST_LEN};
        rd_sum  = {1'b0, rd_addr_q} + {15'd0, BURST_LEN};
        wr_next = (wr_sum >= {1'b0, WR_MAX_ADDR}) ? WR_MIN_ADDR : wr_sum[23:0];
        rd_next = (rd_sum >= {1'b0, RD_MAX_ADDR}) ? RD_MIN_ADDR : rd_sum[23:0];

        state_d     = state_q;
        wr_req_d    = wr_req_q;
        rd_req_d    = rd_req_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        ack_cnt_d   = ack_cnt_q;
        last_wr_d   = last_wr_q;
        wr_pend_d   = wr_pend_q;
        rd_pend_d   = rd_pend_q;
        burst_err_d = burst_err_q;

        if (wr_load && state_q != WRITE) wr_addr_d = WR_MIN_ADDR;
        if (rd_load && state_q != READ)  rd_addr_d = RD_MIN_ADDR;

        case (state_q)
            IDLE: begin
                wr_req_d = 1'b0;
                rd_req_d = 1'b0;
                if (wc && (!rc || !last_wr_q)) begin
                    state_d   = WRITE;
                    ack_cnt_d = 10'd0;
                end else if (rc) begin
                    state_d   = READ;
                    ack_cnt_d = 10'd0;
                end
            end
            WRITE: begin
                wr_req_d = 1'b1;
                if (wr_req_q && sdram_wr_ack) ack_cnt_d = ack_cnt_q + 10'd1;
                if (wr_done) begin
                    state_d   = IDLE;
                    wr_req_d  = 1'b0;
                    last_wr_d = 1'b1;
                    wr_addr_d = (wr_pend_q || wr_load) ? WR_MIN_ADDR : wr_next;
                    wr_pend_d = 1'b0;
                    if (ack_cnt_q != BURST_LEN) burst_err_d = 1'b1;
                end else if (wr_load) begin
                    wr_pend_d = 1'b1;
                end
            end
            READ: begin
                rd_req_d = 1'b1;
                if (rd_req_q && sdram_rd_ack) ack_cnt_d = ack_cnt_q + 10'd1;
                if (rd_done) begin
                    state_d   = IDLE;
                    rd_req_d  = 1'b0;
                    last_wr_d = 1'b0;
                    rd_addr_d = (rd_pend_q || rd_load) ? RD_MIN_ADDR : rd_next;
                    rd_pend_d = 1'b0;
                    if (ack_cnt_q != BURST_LEN) burst_err_d = 1'b1;
                end else if (rd_load) begin
                    rd_pend_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                wr_req_d = 1'b0;
                rd_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_req_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_addr_q   <= WR_MIN_ADDR;
            rd_addr_q   <= RD_MIN_ADDR;
            ack_cnt_q   <= 10'd0;
            wr_ack_d_q  <= 1'b0;
            rd_ack_d_q  <= 1'b0;
            last_wr_q   <= 1'b0;
            wr_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            burst_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_req_q    <= wr_req_d;
            rd_req_q    <= rd_req_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            ack_cnt_q   <= ack_cnt_d;
            wr_ack_d_q  <= sdram_wr_ack;
            rd_ack_d_q  <= sdram_rd_ack;
            last_wr_q   <= last_wr_d;
            wr_pend_q   <= wr_pend_d;
            rd_pend_q   <= rd_pend_d;
            burst_err_q <= burst_err_d;
        end
    end

    assign sdram_wr_req   = wr_req_q;
    assign sdram_rd_req   = rd_req_q;
    assign sdram_wr_addr  = wr_addr_q;
    assign sdram_rd_addr  = rd_addr_q;
    assign sdram_wr_burst = BURST_LEN;
    assign sdram_rd_burst = BURST_LEN;
    assign wrf_rden       = sdram_wr_ack;
    assign rdf_wren       = sdram_rd_ack;
    assign burst_err      = burst_err_q;

endmodule

// File: tb/tb_sdram_burst_master.sv
// Directed bench for sdram_burst_master: table of burst scenarios plus hand-written
// sequences for mid-burst load, continuous arbitration and asynchronous reset.
module tb_sdram_burst_master;

    localparam logic [23:0] WMAX = 24'd1536;
    localparam logic [23:0] RMAX = 24'd1536;
    localparam logic [9:0]  BL   = 10'd512;

    logic        clk, rst_n;
    logic        sdram_init_done, rd_en, wr_load, rd_load;
    logic [9:0]  wrf_use, rdf_use;
    logic        sdram_wr_req, sdram_wr_ack, sdram_rd_req, sdram_rd_ack;
    logic [23:0] sdram_wr_addr, sdram_rd_addr;
    logic [9:0]  sdram_wr_burst, sdram_rd_burst;
    logic        wrf_rden, rdf_wren, burst_err;

    sdram_burst_master #(
        .WR_MIN_ADDR(24'd0), .WR_MAX_ADDR(WMAX),
        .RD_MIN_ADDR(24'd0), .RD_MAX_ADDR(RMAX),
        .BURST_LEN(BL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done),
        .wrf_use(wrf_use), .rdf_use(rdf_use), .rd_en(rd_en),
        .wr_load(wr_load), .rd_load(rd_load),
        .sdram_wr_req(sdram_wr_req), .sdram_wr_ack(sdram_wr_ack),
        .sdram_wr_addr(sdram_wr_addr), .sdram_wr_burst(sdram_wr_burst),
        .sdram_rd_req(sdram_rd_req), .sdram_rd_ack(sdram_rd_ack),
        .sdram_rd_addr(sdram_rd_addr), .sdram_rd_burst(sdram_rd_burst),
        .wrf_rden(wrf_rden), .rdf_wren(rdf_wren), .burst_err(burst_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit        init;
        bit [9:0]  wrf;
        bit [9:0]  rdf;
        bit        rden;
        int        nack;
        int        lag;
        int        dir;    // 0 none, 1 write, 2 read
        bit [23:0] addr;
        bit [23:0] nxt;
        bit        err;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit init, input bit [9:0] wf, input bit [9:0] rf, input bit re);
        sdram_init_done = init;
        wrf_use = wf;
        rdf_use = rf;
        rd_en = re;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
        wr_load = 1'b0; rd_load = 1'b0;
        set_in(1'b0, 10'd0, 10'd0, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Bounded wait for a request; dir 3 flags both requests high together.
    task automatic wait_req(output int dir, output int edges);
        int k;
        dir = 0; edges = 0; k = 0;
        while (dir == 0 && k < 8) begin
            tick();
            k++;
            if (sdram_wr_req && sdram_rd_req) dir = 3;
            else if (sdram_wr_req) dir = 1;
            else if (sdram_rd_req) dir = 2;
            if (dir != 0) edges = k;
        end
    endtask

    // Delivers n acks after lag cycles; counts req drops, address changes and strobe errors.
    task automatic serve(input bit is_wr, input int n, input int lag, input int load_at, output int bad);
        logic [23:0] a0;
        bad = 0;
        a0 = is_wr ? sdram_wr_addr : sdram_rd_addr;
        repeat (lag) begin
            tick();
            if ((is_wr ? sdram_wr_req : sdram_rd_req) !== 1'b1) bad++;
        end
        for (int i = 0; i < n; i++) begin
            if (is_wr) sdram_wr_ack = 1'b1; else sdram_rd_ack = 1'b1;
            if (i == load_at) begin
                if (is_wr) wr_load = 1'b1; else rd_load = 1'b1;
            end
            #1;
            if ((is_wr ? wrf_rden : rdf_wren) !== 1'b1) bad++;
            tick();
            wr_load = 1'b0; rd_load = 1'b0;
            if ((is_wr ? sdram_wr_req : sdram_rd_req) !== 1'b1) bad++;
            if ((is_wr ? sdram_wr_addr : sdram_rd_addr) !== a0) bad++;
        end
        sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
        #1;
        if ((is_wr ? wrf_rden : rdf_wren) !== 1'b0) bad++;
        tick();
    endtask

    initial begin
        int dir, edges, bad;

        //        init wrf     rdf     rden nack lag dir addr      nxt       err
        tv[0]  = '{1'b0, 10'd1000, 10'd0,   1'b1, 0,   0, 0, 24'd0,    24'd0,    1'b0};
        tv[1]  = '{1'b1, 10'd512,  10'd0,   1'b0, 512, 0, 1, 24'd0,    24'd512,  1'b0};
        tv[2]  = '{1'b1, 10'd511,  10'd0,   1'b1, 512, 3, 2, 24'd0,    24'd512,  1'b0};
        tv[3]  = '{1'b1, 10'd600,  10'd511, 1'b1, 512, 0, 1, 24'd512,  24'd1024, 1'b0};
        tv[4]  = '{1'b1, 10'd600,  10'd511, 1'b1, 512, 5, 2, 24'd512,  24'd1024, 1'b0};
        tv[5]  = '{1'b1, 10'd600,  10'd511, 1'b1, 512, 0, 1, 24'd1024, 24'd0,    1'b0};
        tv[6]  = '{1'b1, 10'd512,  10'd0,   1'b0, 512, 1, 1, 24'd0,    24'd512,  1'b0};
        tv[7]  = '{1'b1, 10'd0,    10'd512, 1'b1, 0,   0, 0, 24'd0,    24'd0,    1'b0};
        tv[8]  = '{1'b1, 10'd100,  10'd0,   1'b0, 0,   0, 0, 24'd0,    24'd0,    1'b0};
        tv[9]  = '{1'b1, 10'd0,    10'd0,   1'b1, 512, 0, 2, 24'd1024, 24'd0,    1'b0};
        tv[10] = '{1'b1, 10'd0,    10'd100, 1'b1, 512, 2, 2, 24'd0,    24'd512,  1'b0};
        tv[11] = '{1'b1, 10'd512,  10'd0,   1'b0, 300, 0, 1, 24'd512,  24'd1024, 1'b1};
        tv[12] = '{1'b1, 10'd0,    10'd0,   1'b1, 512, 0, 2, 24'd512,  24'd1024, 1'b1};

        do_reset();
        chk("rst_wr_req", {31'd0, sdram_wr_req}, 32'd0);
        chk("rst_rd_req", {31'd0, sdram_rd_req}, 32'd0);
        chk("rst_wr_addr", {8'd0, sdram_wr_addr}, 32'd0);
        chk("rst_rd_addr", {8'd0, sdram_rd_addr}, 32'd0);
        chk("rst_err", {31'd0, burst_err}, 32'd0);
        chk("wr_burst", {22'd0, sdram_wr_burst}, 32'd512);
        chk("rd_burst", {22'd0, sdram_rd_burst}, 32'd512);

        // Stray ack on an idle port: strobe follows, FSM stays quiet.
        set_in(1'b1, 10'd0, 10'd0, 1'b0);
        sdram_rd_ack = 1'b1;
        #1;
        chk("stray_strobe", {31'd0, rdf_wren}, 32'd1);
        repeat (3) tick();
        sdram_rd_ack = 1'b0;
        chk("stray_noreq", {30'd0, sdram_wr_req, sdram_rd_req}, 32'd0);
        repeat (2) tick();

        for (int i = 0; i < 13; i++) begin
            set_in(tv[i].init, tv[i].wrf, tv[i].rdf, tv[i].rden);
            wait_req(dir, edges);
            chk($sformatf("v%0d_dir", i), dir, tv[i].dir);
            set_in(1'b1, 10'd0, 10'd0, 1'b0);
            if (dir == 1 || dir == 2) begin
                chk($sformatf("v%0d_latency", i), edges, 32'd2);
                chk($sformatf("v%0d_addr", i),
                    {8'd0, (dir == 1) ? sdram_wr_addr : sdram_rd_addr}, {8'd0, tv[i].addr});
                serve(dir == 1, tv[i].nack, tv[i].lag, -1, bad);
                chk($sformatf("v%0d_burst_hold", i), bad, 32'd0);
                chk($sformatf("v%0d_req_drop", i), {30'd0, sdram_wr_req, sdram_rd_req}, 32'd0);
                chk($sformatf("v%0d_next", i),
                    {8'd0, (dir == 1) ? sdram_wr_addr : sdram_rd_addr}, {8'd0, tv[i].nxt});
            end
            chk($sformatf("v%0d_err", i), {31'd0, burst_err}, {31'd0, tv[i].err});
            repeat (2) tick();
        end

        // Mid-burst wr_load, idle rd_load; reset also clears the sticky error.
        do_reset();
        chk("err_cleared", {31'd0, burst_err}, 32'd0);
        for (int b = 0; b < 3; b++) begin
            set_in(1'b1, 10'd512, 10'd0, 1'b0);
            wait_req(dir, edges);
            set_in(1'b1, 10'd0, 10'd0, 1'b0);
            chk($sformatf("ld%0d_dir", b), dir, 32'd1);
            chk($sformatf("ld%0d_addr", b), {8'd0, sdram_wr_addr}, (b == 1) ? 32'd512 : 32'd0);
            serve(1'b1, 512, 0, (b == 1) ? 100 : -1, bad);
            chk($sformatf("ld%0d_hold", b), bad, 32'd0);
            chk($sformatf("ld%0d_next", b), {8'd0, sdram_wr_addr}, (b == 1) ? 32'd0 : 32'd512);
            tick();
        end
        set_in(1'b1, 10'd0, 10'd0, 1'b1);
        wait_req(dir, edges);
        set_in(1'b1, 10'd0, 10'd0, 1'b0);
        chk("rdld_dir", dir, 32'd2);
        serve(1'b0, 512, 0, -1, bad);
        chk("rdld_next", {8'd0, sdram_rd_addr}, 32'd512);
        rd_load = 1'b1;
        tick();
        rd_load = 1'b0;
        chk("rdld_idle", {8'd0, sdram_rd_addr}, 32'd0);
        chk("ld_err", {31'd0, burst_err}, 32'd0);

        // Both conditions held continuously: W,R,W,R with fixed two-edge turnaround.
        do_reset();
        set_in(1'b1, 10'd600, 10'd0, 1'b1);
        for (int b = 0; b < 4; b++) begin
            wait_req(dir, edges);
            chk($sformatf("arb%0d_dir", b), dir, (b % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("arb%0d_gap", b), edges, 32'd2);
            chk($sformatf("arb%0d_addr", b),
                {8'd0, (dir == 1) ? sdram_wr_addr : sdram_rd_addr}, (b < 2) ? 32'd0 : 32'd512);
            serve(dir == 1, 512, 0, -1, bad);
        end

        // Asynchronous reset in the middle of a read burst at address 1024.
        set_in(1'b1, 10'd0, 10'd0, 1'b1);
        wait_req(dir, edges);
        chk("rst_rd_dir", dir, 32'd2);
        chk("rst_rd_addr0", {8'd0, sdram_rd_addr}, 32'd1024);
        sdram_rd_ack = 1'b1;
        repeat (100) tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rd_req", {31'd0, sdram_rd_req}, 32'd0);
        chk("async_rd_addr", {8'd0, sdram_rd_addr}, 32'd0);
        chk("async_strobe", {31'd0, rdf_wren}, 32'd1);
        sdram_rd_ack = 1'b0;
        set_in(1'b0, 10'd1000, 10'd0, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("gate_noreq", {30'd0, sdram_wr_req, sdram_rd_req}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_burst_master.md
# sdram_burst_master

Request-side engine for the SDRAM controller user ports. Watches the write-FIFO fill level and the read-FIFO fill level, raises burst write/read requests on the controller's req/ack ports, and generates circular SDRAM addresses for each direction. Sits between the frame-buffer FIFOs and the SDRAM controller; it strobes the FIFOs directly from the controller's ack signals.

## Interface
- WR_MIN_ADDR, 24'd0, first word address of the write region.
- WR_MAX_ADDR, 24'd786432, exclusive end of the write region.
- RD_MIN_ADDR, 24'd0, first word address of the read region.
- RD_MAX_ADDR, 24'd786432, exclusive end of the read region.
- BURST_LEN, 10'd512, words per burst on both ports. Range 1..1023.

- clk  in  1  controller clock, 100 MHz. Single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- sdram_init_done  in  1  controller initialisation complete.
- wrf_use  in  10  words currently held in the write FIFO.
- rdf_use  in  10  words currently held in the read FIFO.
- rd_en  in  1  read traffic enabled. Level signal.
- wr_load  in  1  one-cycle pulse: restart the write pointer at WR_MIN_ADDR.
- rd_load  in  1  one-cycle pulse: restart the read pointer at RD_MIN_ADDR.
- sdram_wr_req  out  1  burst write request.
- sdram_wr_ack  in  1  controller write data strobe. High one cycle per word taken.
- sdram_wr_addr  out  24  burst start address {bank, row, col}.
- sdram_wr_burst  out  10  constant BURST_LEN.
- sdram_rd_req  out  1  burst read request.
- sdram_rd_ack  in  1  controller read data valid. High one cycle per word.
- sdram_rd_addr  out  24  burst start address.
- sdram_rd_burst  out  10  constant BURST_LEN.
- wrf_rden  out  1  write-FIFO read enable. Combinational copy of sdram_wr_ack.
- rdf_wren  out  1  read-FIFO write enable. Combinational copy of sdram_rd_ack.
- burst_err  out  1  sticky: a burst completed with an ack count different from BURST_LEN.

## Operation
- FSM states: IDLE, WRITE, READ. Reset state is IDLE.
- Write condition (wc): sdram_init_done && wrf_use >= BURST_LEN.
- Read condition (rc): sdram_init_done && rd_en && rdf_use < BURST_LEN.
- IDLE transitions:
  - wc only → WRITE.
  - rc only → READ.
  - Both → the direction not served last. A `last_wr` flag tracks this; it resets to 0, so the first tie goes to WRITE.
  - Neither → stay in IDLE.
- WRITE: sdram_wr_req is held at 1 until burst done.
  - Burst done = falling edge of sdram_wr_ack (registered ack_d=1, ack=0).
  - On done → IDLE, req=0, last_wr=1, write pointer advances.
- READ: same sequence using the rd signals. On done, last_wr=0.
- Ack cycles are counted per burst (10-bit counter, cleared on entry).
  - If count != BURST_LEN at done, burst_err is set.
  - burst_err clears only on reset.
- Pointer advance: next = (addr + BURST_LEN >= MAX) ? MIN : addr + BURST_LEN. Compute in 25 bits, with no overflow.
- sdram_*_addr outputs are the registered pointers. They are stable for the whole time req is high.
- wr_load / rd_load handling:
  - If that direction is not active, the pointer is loaded with MIN on the next edge.
  - If that direction is mid-burst, a pending flag is set. At burst done the pointer loads MIN instead of advancing.
- sdram_init_done falling mid-burst: the current burst completes normally. No new request is issued while it is low.
- Ack on the inactive port is ignored by the FSM. It still passes through to the FIFO strobe.

## Timing
- Reset values:
  - sdram_wr_req=0, sdram_rd_req=0, burst_err=0, state=IDLE.
  - sdram_wr_addr=WR_MIN_ADDR, sdram_rd_addr=RD_MIN_ADDR.
  - sdram_*_burst=BURST_LEN.
  - wrf_rden and rdf_wren follow their acks, which are 0 while the controller is in reset.
- Condition true in IDLE at edge N → req=1 after edge N+1 (1-cycle latency).
- Last ack high in cycle M-1, low in cycle M → done detected in cycle M.
  - After edge M: req=0, pointer updated, state=IDLE.
  - Earliest next req high after edge M+2.
- req never drops before done. The controller's ack may lag req by any number of cycles.
- Reset is asynchronous. Asserting it mid-burst returns all registers to reset values immediately; in-flight data is discarded.

## Test plan
- Write trigger: init_done=1, wrf_use=512, BURST_LEN=512.
  - Response: wr_req rises 1 cycle later and holds through 512 ack cycles.
  - wrf_rden mirrors ack exactly.
  - Next sdram_wr_addr=512. burst_err=0.
- Wrap: WR_MAX_ADDR=1536, BURST_LEN=512. Run 3 bursts.
  - Response: addresses 0, 512, 1024, then the pointer returns to 0 (1024+512 >= 1536).
- Arbitration: wc and rc both true continuously.
  - Response: bursts alternate W, R, W, R starting with W. There is a 1-cycle IDLE gap between each.
- Mid-burst load: pulse wr_load during write burst #2 at address 512.
  - Response: that burst completes, the pointer becomes WR_MIN_ADDR (not 1024), and the next write addr=0.
- Short burst: controller delivers 300 acks instead of 512.
  - Response: burst_err=1 after done, remains 1 until rst_n=0.
- Gating: init_done=0 with wrf_use=1000 → no req. Drop rst_n mid-read → rd_req=0 and rd_addr=RD_MIN_ADDR asynchronously.
